// File: rtl/rgbw_fade_sequencer_pkg.sv
// ============================================================================
// Module : rgbw_fade_sequencer_pkg
// Brief  : Shared FSM encodings, channel indices and defaults for the RGBW fader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rgbw_fade_sequencer_pkg;

    localparam int unsigned c_tick_div_default = 12000;

    localparam logic [1:0] c_ch_r = 2'd0;
    localparam logic [1:0] c_ch_g = 2'd1;
    localparam logic [1:0] c_ch_b = 2'd2;
    localparam logic [1:0] c_ch_w = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CH_R  = 3'd1,
        ST_CH_G  = 3'd2,
        ST_CH_B  = 3'd3,
        ST_CH_W  = 3'd4,
        ST_CHECK = 3'd5
    } state_e;

    // Perceptual curve (cur*cur + 255) >> 8 keeps 0 -> 0 and 255 -> 255.
    function automatic logic [7:0] f_gamma(input logic [7:0] lvl);
        logic [16:0] sq;
        sq = 17'(lvl) * 17'(lvl) + 17'd255;
        return 8'(sq >> 8);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rgbw_fade_step.sv
// ============================================================================
// Module : rgbw_fade_step
// Brief  : Combinational step unit moving one level toward its target, clamped.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rgbw_fade_step (
    input  logic [7:0] cur_i,
    input  logic [7:0] tgt_i,
    input  logic [7:0] step_i,
    output logic [7:0] nxt_o
);

    logic        [8:0] w_sum;
    logic signed [9:0] w_dif;

    assign w_sum = {1'b0, cur_i} + {1'b0, step_i};
    assign w_dif = $signed({2'b00, cur_i}) - $signed({2'b00, step_i});

    always_comb begin
        nxt_o = cur_i;
        if (cur_i < tgt_i) begin
            nxt_o = (w_sum > {1'b0, tgt_i}) ? tgt_i : w_sum[7:0];
        end else if (cur_i > tgt_i) begin
            nxt_o = (w_dif < $signed({2'b00, tgt_i})) ? tgt_i : w_dif[7:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/rgbw_fade_sequencer.sv
// ============================================================================
// Module : rgbw_fade_sequencer
// Brief  : Ramps four lamp levels toward loaded targets, one channel per cycle
//          on each prescaler tick. Option macro: RGBW_FADE_GAMMA_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rgbw_fade_sequencer
    import rgbw_fade_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV = c_tick_div_default
) (
    input  logic       clk12,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] red_tgt,
    input  logic [7:0] green_tgt,
    input  logic [7:0] blue_tgt,
    input  logic [7:0] white_tgt,
    input  logic [7:0] step_in,
    output logic [7:0] red_out,
    output logic [7:0] green_out,
    output logic [7:0] blue_out,
    output logic [7:0] white_out,
    output logic       busy,
    output logic       done
);

    logic [15:0] cnt_q, cnt_d;
    state_e      state_q, state_d;
    logic [7:0]  lvl_q [4];
    logic [7:0]  lvl_d [4];
    logic [7:0]  tgt_q [4];
    logic [7:0]  tgt_d [4];
    logic [7:0]  step_q, step_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        w_tick;
    logic        w_upd;
    logic [1:0]  w_sel;
    logic [7:0]  w_nxt;
    logic        w_all_eq;
    logic        w_any_diff_new;

    assign w_tick = (cnt_q == 16'(TICK_DIV - 1));
    assign cnt_d  = w_tick ? 16'd0 : cnt_q + 16'd1;

    always_comb begin
        w_upd = 1'b1;
        w_sel = c_ch_r;
        case (state_q)
            ST_CH_R: w_sel = c_ch_r;
            ST_CH_G: w_sel = c_ch_g;
            ST_CH_B: w_sel = c_ch_b;
            ST_CH_W: w_sel = c_ch_w;
            default: w_upd = 1'b0;
        endcase
    end

    rgbw_fade_step u_step (
        .cur_i  (lvl_q[w_sel]),
        .tgt_i  (tgt_q[w_sel]),
        .step_i (step_q),
        .nxt_o  (w_nxt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_tick && busy_q) state_d = ST_CH_R;
            ST_CH_R:  state_d = ST_CH_G;
            ST_CH_G:  state_d = ST_CH_B;
            ST_CH_B:  state_d = ST_CH_W;
            ST_CH_W:  state_d = ST_CHECK;
            default:  state_d = ST_IDLE;
        endcase
    end

    // New targets are compared against the post-update levels so that a load
    // coinciding with a channel update never leaves busy stuck low.
    always_comb begin
        lvl_d = lvl_q;
        if (w_upd) lvl_d[w_sel] = w_nxt;

        tgt_d  = tgt_q;
        step_d = step_q;
        if (load) begin
            tgt_d[c_ch_r] = red_tgt;
            tgt_d[c_ch_g] = green_tgt;
            tgt_d[c_ch_b] = blue_tgt;
            tgt_d[c_ch_w] = white_tgt;
            step_d        = (step_in == 8'd0) ? 8'd1 : step_in;
        end

        w_all_eq       = 1'b1;
        w_any_diff_new = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (lvl_q[i] != tgt_q[i]) w_all_eq = 1'b0;
            if (tgt_d[i] != lvl_d[i]) w_any_diff_new = 1'b1;
        end

        busy_d = busy_q;
        done_d = 1'b0;
        if (load) begin
            busy_d = w_any_diff_new;
        end else if (state_q == ST_CHECK && w_all_eq) begin
            busy_d = 1'b0;
            done_d = busy_q;
        end
    end

    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) begin
            cnt_q   <= 16'd0;
            state_q <= ST_IDLE;
            step_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                lvl_q[i] <= 8'd0;
                tgt_q[i] <= 8'd0;
            end
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lvl_q   <= lvl_d;
            tgt_q   <= tgt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

`ifdef RGBW_FADE_GAMMA_EN
    logic [7:0] out_q [4];

    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) out_q[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) out_q[i] <= f_gamma(lvl_q[i]);
        end
    end

    assign red_out   = out_q[c_ch_r];
    assign green_out = out_q[c_ch_g];
    assign blue_out  = out_q[c_ch_b];
    assign white_out = out_q[c_ch_w];
`else
    assign red_out   = lvl_q[c_ch_r];
    assign green_out = lvl_q[c_ch_g];
    assign blue_out  = lvl_q[c_ch_b];
    assign white_out = lvl_q[c_ch_w];
`endif

endmodule

`default_nettype wire

// File: tb/tb_rgbw_fade_sequencer.sv
// ============================================================================
// Module : tb_rgbw_fade_sequencer
// Brief  : Table-driven scoreboard bench for the RGBW fade sequencer (TICK_DIV=8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rgbw_fade_sequencer;

    localparam int TD = 8;

    logic       clk12 = 1'b0;
    logic       reset = 1'b1;
    logic       load  = 1'b0;
    logic [7:0] red_tgt = '0, green_tgt = '0, blue_tgt = '0, white_tgt = '0, step_in = '0;
    logic [7:0] red_out, green_out, blue_out, white_out;
    logic       busy, done;
    logic [31:0] outs;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int m [4] = '{0, 0, 0, 0};
    logic [31:0] sbq [$];

    typedef struct {
        int t [4];
        int step;
        int ndone;
    } vec_t;
    vec_t vecs [7];

    rgbw_fade_sequencer #(.TICK_DIV(TD)) dut (
        .clk12     (clk12),
        .reset     (reset),
        .load      (load),
        .red_tgt   (red_tgt),
        .green_tgt (green_tgt),
        .blue_tgt  (blue_tgt),
        .white_tgt (white_tgt),
        .step_in   (step_in),
        .red_out   (red_out),
        .green_out (green_out),
        .blue_out  (blue_out),
        .white_out (white_out),
        .busy      (busy),
        .done      (done)
    );

    assign outs = {red_out, green_out, blue_out, white_out};

    always #5 clk12 = ~clk12;

    always @(posedge clk12) if (done === 1'b1) done_cnt <= done_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {a[7:0], b[7:0], c[7:0], d[7:0]};
    endfunction

    task automatic do_load(input int t0, input int t1, input int t2, input int t3, input int st);
        @(posedge clk12); #1;
        red_tgt = 8'(t0); green_tgt = 8'(t1); blue_tgt = 8'(t2); white_tgt = 8'(t3);
        step_in = 8'(st);
        load = 1'b1;
        @(posedge clk12); #1;
        load = 1'b0;
    endtask

    // Reference ramp: push one settled snapshot per tick until all reach target.
    task automatic model_push(input vec_t v);
        int e;
        bit moving;
        e = (v.step == 0) ? 1 : v.step;
        moving = 1'b1;
        while (moving) begin
            moving = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (m[i] < v.t[i]) begin
                    m[i] = (m[i] + e > v.t[i]) ? v.t[i] : m[i] + e;
                    moving = 1'b1;
                end else if (m[i] > v.t[i]) begin
                    m[i] = (m[i] - e < v.t[i]) ? v.t[i] : m[i] - e;
                    moving = 1'b1;
                end
            end
            if (moving) sbq.push_back(pack4(m[0], m[1], m[2], m[3]));
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] last, exp;
        int d0, cyc, first_lat;
        bit hit;
        d0 = done_cnt;
        model_push(v);
        do_load(v.t[0], v.t[1], v.t[2], v.t[3], v.step);
        last = outs;
        first_lat = -1;
        cyc = 0;
        while (sbq.size() > 0) begin
            hit = 1'b0;
            for (int k = 0; k < 3 * TD; k++) begin
                @(negedge clk12);
                cyc++;
                if (outs != last) begin
                    hit = 1'b1;
                    break;
                end
            end
            if (!hit) begin
                chk($sformatf("v%0d_change_timeout", idx), 32'd0, 32'd1);
                sbq.delete();
                break;
            end
            if (first_lat < 0) first_lat = cyc;
            repeat (4) @(negedge clk12);
            exp = sbq.pop_front();
            chk($sformatf("v%0d_levels", idx), outs, exp);
            last = outs;
        end
        if (idx == 0) chk("first_change_within_tickdiv_plus1", 32'(first_lat <= TD + 1), 32'd1);
        repeat (12) @(negedge clk12);
        chk($sformatf("v%0d_busy_idle", idx), 32'(busy), 32'd0);
        chk($sformatf("v%0d_done_pulses", idx), 32'(done_cnt - d0), 32'(v.ndone));
    endtask

    initial begin
        int d0;
        bit viol, reached;

        vecs[0] = '{'{10, 0, 0, 0},      4,   1};
        vecs[1] = '{'{2, 2, 2, 2},       0,   1};
        vecs[2] = '{'{0, 0, 0, 200},     255, 1};
        vecs[3] = '{'{0, 0, 0, 3},       255, 1};
        vecs[4] = '{'{255, 128, 64, 0},  50,  1};
        vecs[5] = '{'{255, 128, 64, 0},  7,   0};
        vecs[6] = '{'{0, 128, 64, 0},    255, 1};

        repeat (3) @(negedge clk12);
        chk("reset_levels", outs, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Retarget red downward while it is still ramping up.
        do_load(200, 128, 64, 0, 10);
        reached = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk12);
            if (red_out == 8'd100) begin
                reached = 1'b1;
                break;
            end
        end
        chk("retarget_reach_100", 32'(reached), 32'd1);
        d0 = done_cnt;
        do_load(0, 128, 64, 0, 10);
        viol = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk12);
            if (red_out > 8'd100) viol = 1'b1;
            if (red_out == 8'd0) begin
                reached = 1'b1;
                break;
            end
        end
        chk("retarget_no_rise", 32'(viol), 32'd0);
        chk("retarget_reach_0", 32'(reached), 32'd1);
        chk("retarget_no_early_done", 32'(done_cnt - d0), 32'd0);
        repeat (10) @(negedge clk12);
        chk("retarget_single_done", 32'(done_cnt - d0), 32'd1);
        chk("retarget_busy_low", 32'(busy), 32'd0);
        chk("retarget_levels", outs, pack4(0, 128, 64, 0));

        // Asynchronous reset in the middle of a ramp.
        do_load(255, 255, 255, 255, 1);
        repeat (30) @(negedge clk12);
        chk("midramp_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_levels", outs, 32'd0);
        chk("async_reset_busy", 32'(busy), 32'd0);
        chk("async_reset_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk12);
        reset = 1'b0;
        repeat (3 * TD) @(negedge clk12);
        chk("post_reset_levels", outs, 32'd0);
        chk("post_reset_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
